// File: rtl/arf_sequencer.sv
// rtl/arf_sequencer.sv - address register file micro-op sequencer
// Expands one accepted command into up to three Moore control words for the PC/AR/SP file and memory.
module arf_sequencer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd,
  input  logic [15:0] target,
  output logic        cmd_ready,
  output logic        done,
  output logic [2:0]  arf_fun_sel,
  output logic [2:0]  arf_reg_sel,
  output logic [1:0]  arf_out_c_sel,
  output logic [1:0]  arf_out_d_sel,
  output logic        arf_i_sel,
  output logic        mem_cs,
  output logic        mem_wr,
  output logic [15:0] arf_target
);

  typedef enum logic [1:0] {IDLE = 2'd0, E1 = 2'd1, E2 = 2'd2, E3 = 2'd3} state_t;

  localparam logic [2:0] OP_FETCH = 3'b001;
  localparam logic [2:0] OP_JUMP  = 3'b010;
  localparam logic [2:0] OP_PUSH  = 3'b011;
  localparam logic [2:0] OP_POP   = 3'b100;
  localparam logic [2:0] OP_CALL  = 3'b101;
  localparam logic [2:0] OP_RET   = 3'b110;
  localparam logic [2:0] OP_LDAR  = 3'b111;

  localparam logic [2:0] FUN_DEC  = 3'b000;
  localparam logic [2:0] FUN_INC  = 3'b001;
  localparam logic [2:0] FUN_LOAD = 3'b010;

  localparam logic [2:0] EN_NONE = 3'b111;
  localparam logic [2:0] EN_PC   = 3'b011;
  localparam logic [2:0] EN_AR   = 3'b101;
  localparam logic [2:0] EN_SP   = 3'b110;

  localparam logic [1:0] SEL_PC = 2'b00;
  localparam logic [1:0] SEL_AR = 2'b10;
  localparam logic [1:0] SEL_SP = 2'b11;

  state_t      state_q, state_d;
  logic [2:0]  cmd_q, cmd_d;
  logic [15:0] target_q, target_d;
  logic [1:0]  cmd_len;
  logic        last_step;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cmd_q    <= 3'b000;
      target_q <= 16'h0000;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      target_q <= target_d;
    end
  end

  // Enum values double as the step number, so the last step is where state equals length.
  always_comb begin
    case (cmd_q)
      OP_FETCH, OP_PUSH, OP_POP, OP_RET: cmd_len = 2'd2;
      OP_CALL:                           cmd_len = 2'd3;
      default:                           cmd_len = 2'd1;
    endcase
    last_step = (state_q != IDLE) && (state_q == state_t'(cmd_len));
  end

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    target_d = target_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          state_d  = E1;
          cmd_d    = cmd;
          target_d = target;
        end
      end
      E1:      state_d = last_step ? IDLE : E2;
      E2:      state_d = last_step ? IDLE : E3;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    arf_reg_sel   = EN_NONE;
    arf_fun_sel   = FUN_DEC;
    arf_out_c_sel = SEL_PC;
    arf_out_d_sel = SEL_PC;
    arf_i_sel     = 1'b0;
    mem_cs        = 1'b1;
    mem_wr        = 1'b0;
    if (state_q != IDLE) begin
      case (cmd_q)
        OP_FETCH: begin
          if (state_q == E1) begin
            mem_cs = 1'b0;
          end else if (state_q == E2) begin
            arf_reg_sel = EN_PC;
            arf_fun_sel = FUN_INC;
          end
        end
        OP_JUMP: begin
          arf_reg_sel = EN_PC;
          arf_fun_sel = FUN_LOAD;
        end
        OP_LDAR: begin
          arf_reg_sel = EN_AR;
          arf_fun_sel = FUN_LOAD;
        end
        OP_PUSH, OP_CALL: begin
          if (state_q == E1) begin
            arf_reg_sel = EN_SP;
          end else if (state_q == E2) begin
            arf_out_d_sel = SEL_SP;
            arf_out_c_sel = (cmd_q == OP_PUSH) ? SEL_AR : SEL_PC;
            mem_cs        = 1'b0;
            mem_wr        = 1'b1;
          end else if (cmd_q == OP_CALL) begin
            arf_reg_sel = EN_PC;
            arf_fun_sel = FUN_LOAD;
          end
        end
        OP_POP, OP_RET: begin
          if (state_q == E1) begin
            arf_out_d_sel = SEL_SP;
            mem_cs        = 1'b0;
            if (cmd_q == OP_RET) begin
              arf_reg_sel = EN_PC;
              arf_fun_sel = FUN_LOAD;
              arf_i_sel   = 1'b1;
            end
          end else if (state_q == E2) begin
            arf_reg_sel = EN_SP;
            arf_fun_sel = FUN_INC;
          end
        end
        default: ;
      endcase
    end
  end

  assign done       = last_step;
  assign cmd_ready  = (state_q == IDLE);
  assign arf_target = target_q;

endmodule

// File: tb/tb_arf_sequencer.sv
// tb/tb_arf_sequencer.sv - directed bench for arf_sequencer
// Models the PC/AR/SP file and a 64K-word memory, and scores control words and register results.
module tb_arf_sequencer;

  localparam logic [2:0] C_NOP = 3'b000, C_FETCH = 3'b001, C_JUMP = 3'b010, C_PUSH = 3'b011;
  localparam logic [2:0] C_POP = 3'b100, C_CALL = 3'b101, C_RET = 3'b110, C_LDAR = 3'b111;
  localparam logic [13:0] W_DEFAULT = 14'b111_000_00_00_0_1_0_0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd = 3'b000;
  logic [15:0] target = 16'h0000;
  logic        cmd_ready, done, arf_i_sel, mem_cs, mem_wr;
  logic [2:0]  arf_fun_sel, arf_reg_sel;
  logic [1:0]  arf_out_c_sel, arf_out_d_sel;
  logic [15:0] arf_target;

  arf_sequencer dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd(cmd), .target(target),
    .cmd_ready(cmd_ready), .done(done), .arf_fun_sel(arf_fun_sel), .arf_reg_sel(arf_reg_sel),
    .arf_out_c_sel(arf_out_c_sel), .arf_out_d_sel(arf_out_d_sel), .arf_i_sel(arf_i_sel),
    .mem_cs(mem_cs), .mem_wr(mem_wr), .arf_target(arf_target)
  );

  always #5 clk = ~clk;

  logic [15:0] pc, ar, sp;
  bit   [15:0] mem [0:65535];
  bit          wr_mark [0:65535];
  logic        pre = 1'b0;
  logic [15:0] pre_pc = 16'h0, pre_ar = 16'h0, pre_sp = 16'h0;
  logic [15:0] addr, wdata, i_val;

  wire [13:0] word = {arf_reg_sel, arf_fun_sel, arf_out_c_sel, arf_out_d_sel,
                      arf_i_sel, mem_cs, mem_wr, done};

  always_comb begin
    case (arf_out_d_sel)
      2'b00:   addr = pc;
      2'b10:   addr = ar;
      2'b11:   addr = sp;
      default: addr = 16'h0;
    endcase
    case (arf_out_c_sel)
      2'b00:   wdata = pc;
      2'b10:   wdata = ar;
      2'b11:   wdata = sp;
      default: wdata = 16'h0;
    endcase
    i_val = arf_i_sel ? mem[addr] : arf_target;
  end

  function automatic logic [15:0] apply_fun(input logic [15:0] v, input logic [2:0] f, input logic [15:0] i);
    case (f)
      3'b000:  return v - 16'd1;
      3'b001:  return v + 16'd1;
      3'b010:  return i;
      3'b011:  return 16'h0;
      default: return v;
    endcase
  endfunction

  always @(posedge clk) begin
    if (pre) begin
      pc <= pre_pc;
      ar <= pre_ar;
      sp <= pre_sp;
    end else begin
      if (!mem_cs && mem_wr) begin
        mem[addr]     <= wdata;
        wr_mark[addr] <= 1'b1;
      end
      if (!arf_reg_sel[2]) pc <= apply_fun(pc, arf_fun_sel, i_val);
      if (!arf_reg_sel[1]) ar <= apply_fun(ar, arf_fun_sel, i_val);
      if (!arf_reg_sel[0]) sp <= apply_fun(sp, arf_fun_sel, i_val);
    end
  end

  function automatic int cmd_len(input logic [2:0] c);
    case (c)
      C_FETCH, C_PUSH, C_POP, C_RET: return 2;
      C_CALL:                        return 3;
      default:                       return 1;
    endcase
  endfunction

  function automatic logic [13:0] exp_word(input logic [2:0] c, input int s);
    logic [2:0] rs = 3'b111;
    logic [2:0] fs = 3'b000;
    logic [1:0] oc = 2'b00;
    logic [1:0] od = 2'b00;
    logic is = 1'b0, cs = 1'b1, wr = 1'b0;
    case (c)
      C_FETCH: if (s == 1) cs = 1'b0; else begin rs = 3'b011; fs = 3'b001; end
      C_JUMP:  begin rs = 3'b011; fs = 3'b010; end
      C_LDAR:  begin rs = 3'b101; fs = 3'b010; end
      C_PUSH:  if (s == 1) rs = 3'b110; else begin od = 2'b11; oc = 2'b10; cs = 1'b0; wr = 1'b1; end
      C_POP:   if (s == 1) begin od = 2'b11; cs = 1'b0; end else begin rs = 3'b110; fs = 3'b001; end
      C_CALL: begin
        if (s == 1) rs = 3'b110;
        else if (s == 2) begin od = 2'b11; oc = 2'b00; cs = 1'b0; wr = 1'b1; end
        else begin rs = 3'b011; fs = 3'b010; end
      end
      C_RET: begin
        if (s == 1) begin od = 2'b11; cs = 1'b0; rs = 3'b011; fs = 3'b010; is = 1'b1; end
        else begin rs = 3'b110; fs = 3'b001; end
      end
      default: ;
    endcase
    return {rs, fs, oc, od, is, cs, wr, (s == cmd_len(c))};
  endfunction

  typedef struct packed { logic [15:0] pc; logic [15:0] ar; logic [15:0] sp; } regs_t;
  regs_t       sb_regs [$];
  logic [13:0] sb_word [$];
  int          n_tests = 0;
  int          n_fail = 0;
  logic [15:0] e1_addr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preset(input logic [15:0] p, input logic [15:0] a, input logic [15:0] s);
    @(negedge clk);
    pre = 1'b1; pre_pc = p; pre_ar = a; pre_sp = s;
    @(posedge clk);
    #1 pre = 1'b0;
  endtask

  // Target is scrambled right after accept so a late sample would load the wrong value.
  task automatic issue(input string tag, input logic [2:0] c, input logic [15:0] t, input regs_t exp);
    regs_t r;
    sb_regs.push_back(exp);
    for (int s = 1; s <= cmd_len(c); s++) sb_word.push_back(exp_word(c, s));
    @(negedge clk);
    check({tag, "_ready_idle"}, 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd = c; target = t;
    @(posedge clk);
    #1 cmd_valid = 1'b0; target = ~t;
    for (int s = 1; s <= cmd_len(c); s++) begin
      @(negedge clk);
      if (s == 1) e1_addr = addr;
      check($sformatf("%s_word_e%0d", tag, s), 32'(word), 32'(sb_word.pop_front()));
      check($sformatf("%s_busy_e%0d", tag, s), 32'(cmd_ready), 32'd0);
    end
    @(negedge clk);
    check({tag, "_ready_after"}, 32'(cmd_ready), 32'd1);
    check({tag, "_idle_word"}, 32'(word), 32'(W_DEFAULT));
    r = sb_regs.pop_front();
    check({tag, "_pc"}, 32'(pc), 32'(r.pc));
    check({tag, "_ar"}, 32'(ar), 32'(r.ar));
    check({tag, "_sp"}, 32'(sp), 32'(r.sp));
  endtask

  initial begin
    #2;
    check("rst_word", 32'(word), 32'(W_DEFAULT));
    check("rst_ready", 32'(cmd_ready), 32'd1);
    check("rst_target", 32'(arf_target), 32'd0);
    preset(16'h0010, 16'h0000, 16'h0100);
    @(negedge clk);
    rst_n = 1'b1;

    issue("fetch", C_FETCH, 16'hAAAA, '{pc: 16'h0011, ar: 16'h0000, sp: 16'h0100});

    preset(16'h0034, 16'h0000, 16'h0100);
    issue("call", C_CALL, 16'h0200, '{pc: 16'h0200, ar: 16'h0000, sp: 16'h00FF});
    check("call_mem", 32'(mem[16'h00FF]), 32'h0034);
    issue("ret", C_RET, 16'h0000, '{pc: 16'h0034, ar: 16'h0000, sp: 16'h0100});

    preset(16'h0034, 16'hBEEF, 16'h0000);
    issue("push", C_PUSH, 16'h0000, '{pc: 16'h0034, ar: 16'hBEEF, sp: 16'hFFFF});
    check("push_mem", 32'(mem[16'hFFFF]), 32'h0000BEEF);
    issue("pop", C_POP, 16'h0000, '{pc: 16'h0034, ar: 16'hBEEF, sp: 16'h0000});
    check("pop_addr", 32'(e1_addr), 32'h0000FFFF);
    issue("nop", C_NOP, 16'h4444, '{pc: 16'h0034, ar: 16'hBEEF, sp: 16'h0000});

    // CmdValid held across two back-to-back commands.
    @(negedge clk);
    cmd_valid = 1'b1; cmd = C_JUMP; target = 16'h1234;
    @(posedge clk);
    #1 cmd = C_LDAR; target = 16'h5678;
    @(negedge clk);
    check("hs_jump_word", 32'(word), 32'(exp_word(C_JUMP, 1)));
    check("hs_jump_busy", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    check("hs_idle_ready", 32'(cmd_ready), 32'd1);
    check("hs_jump_pc", 32'(pc), 32'h1234);
    @(posedge clk);
    #1 cmd_valid = 1'b0; target = 16'h9999;
    @(negedge clk);
    check("hs_ldar_word", 32'(word), 32'(exp_word(C_LDAR, 1)));
    @(negedge clk);
    check("hs_ldar_ar", 32'(ar), 32'h5678);
    check("hs_ready_after", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    check("hs_no_extra_accept", 32'(cmd_ready), 32'd1);

    // Reset lands in the middle of CALL's memory-write cycle.
    preset(16'h0050, 16'h0000, 16'h0200);
    @(negedge clk);
    cmd_valid = 1'b1; cmd = C_CALL; target = 16'h0300;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(negedge clk);
    check("rc_e1_word", 32'(word), 32'(exp_word(C_CALL, 1)));
    @(negedge clk);
    check("rc_e2_word", 32'(word), 32'(exp_word(C_CALL, 2)));
    #1 rst_n = 1'b0;
    #1;
    check("rc_mem_cs", 32'(mem_cs), 32'd1);
    check("rc_reg_sel", 32'(arf_reg_sel), 32'b111);
    check("rc_word", 32'(word), 32'(W_DEFAULT));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rc_ready", 32'(cmd_ready), 32'd1);
    check("rc_target_clr", 32'(arf_target), 32'd0);
    check("rc_sp", 32'(sp), 32'h01FF);
    check("rc_pc", 32'(pc), 32'h0050);
    check("rc_mem_unwritten", 32'(wr_mark[16'h01FF]), 32'd0);
    issue("rc_post", C_JUMP, 16'h0777, '{pc: 16'h0777, ar: 16'h0000, sp: 16'h01FF});

    check("sb_empty", 32'(sb_regs.size() + sb_word.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/arf_sequencer.md
# arf_sequencer

Micro-operation sequencer for the address register file (PC, AR, SP). It accepts one command at a time over a valid/ready handshake and expands it into a fixed sequence of register-file control words and memory strobes. Supported commands are fetch, jump, push, pop, call, return and AR load. It sits between the instruction decoder and the address register file / memory pair, and is the only block that drives the register file's control inputs.

## Interface
- No parameters; command encoding and widths are fixed.
- Clock  input  1  single clock, rising edge.
- Reset  input  1  asynchronous, active-low; forces IDLE.
- CmdValid  input  1  command request.
- Cmd  input  3  opcode:
  - 000 NOP
  - 001 FETCH
  - 010 JUMP
  - 011 PUSH
  - 100 POP
  - 101 CALL
  - 110 RET
  - 111 LDAR
- Target  input  16  jump/call target or AR value; latched on accept.
- CmdReady  output  1  high only in IDLE.
- Done  output  1  high during the final execution cycle of a command.
- ArfFunSel  output  3  register function:
  - 000 decrement
  - 001 increment
  - 010 load I
  - 011 clear
- ArfRegSel  output  3  active-low enables; bit2 PC, bit1 AR, bit0 SP; 111 holds all registers.
- ArfOutCSel  output  2  00 PC, 10 AR, 11 SP; OutC is memory write data.
- ArfOutDSel  output  2  same encoding; OutD is memory address.
- ArfISel  output  1  register-file I source: 0 latched Target, 1 memory read data.
- MemCS  output  1  memory chip select, active-low.
- MemWR  output  1  1 write, 0 read; meaningful only when MemCS=0.

## Operation
- States: IDLE, E1, E2, E3. The latched opcode selects the per-state control word. All outputs are Moore, decoded from state and latched opcode.
- Default word, used in IDLE, in unused states, and after reset:
  - ArfRegSel=111, ArfFunSel=000
  - ArfOutCSel=00, ArfOutDSel=00
  - ArfISel=0, MemCS=1, MemWR=0
  - Done=0
- Accept: a rising edge with CmdValid=1 in IDLE latches Cmd and Target, then moves to E1. CmdValid in any other state is ignored; the requester holds it.
- Sequences (the last listed cycle asserts Done, then the block returns to IDLE):
  - NOP: E1 uses the default word.
  - FETCH:
    - E1: OutDSel=00, MemCS=0, MemWR=0.
    - E2: RegSel=011, FunSel=001 (PC+1).
  - JUMP: E1: RegSel=011, FunSel=010, ISel=0.
  - LDAR: E1: RegSel=101, FunSel=010, ISel=0.
  - PUSH:
    - E1: RegSel=110, FunSel=000 (SP-1).
    - E2: OutDSel=11, OutCSel=10 (AR as data), MemCS=0, MemWR=1.
  - POP:
    - E1: OutDSel=11, MemCS=0, MemWR=0 (data is consumed externally).
    - E2: RegSel=110, FunSel=001.
  - CALL:
    - E1: SP-1.
    - E2: OutDSel=11, OutCSel=00, MemCS=0, MemWR=1 (mem[SP]←PC).
    - E3: RegSel=011, FunSel=010, ISel=0 (PC←Target).
  - RET:
    - E1: OutDSel=11, MemCS=0, MemWR=0, RegSel=011, FunSel=010, ISel=1 (PC←mem[SP]).
    - E2: SP+1.
- The stack grows downward. SP points at the last pushed word.
- SP and PC wrap modulo 2^16 through the register itself. This block does no overflow checking.

## Timing
- Accept edge k; E1 occupies cycle k+1.
- Done is high in the final cycle of the command: cycle k+1 for 1-cycle commands, k+2 for 2-cycle commands, k+3 for CALL.
- CmdReady rises in the cycle after Done. Issue interval is (command length + 1) cycles.
- Memory reads are combinational. RET loads PC from read data on the same edge that ends E1.
- Target is sampled only at accept; later changes have no effect.
- Reset asserted at any time:
  - State goes to IDLE and the latched Cmd/Target clear to 0.
  - Outputs take the default word immediately, without waiting for a clock edge.
- Register contents are not restored. A CALL interrupted after E1 leaves SP decremented.
- Reset release: the first accept is possible on the first rising edge with Reset=1.

## Test plan
- Reset mid-CALL, asserted in E2:
  - MemCS=1 and RegSel=111 within the same cycle.
  - After release, CmdReady=1.
  - SP stays at its decremented value and memory is unwritten.
- FETCH with PC=0x0010:
  - E1 shows OutDSel=00, MemCS=0, MemWR=0.
  - E2 shows RegSel=011, FunSel=001.
  - PC=0x0011 and Done high in E2; CmdReady high the next cycle.
- CALL with Target=0x0200, PC=0x0034, SP=0x0100:
  - Final state SP=0x00FF, mem[0x00FF]=0x0034, PC=0x0200.
  - Done in the third cycle after accept.
- RET right after that CALL: PC=0x0034, SP=0x0100, two cycles.
- PUSH with AR=0xBEEF, SP=0x0000, then POP:
  - PUSH: SP wraps to 0xFFFF and mem[0xFFFF]=0xBEEF.
  - POP: read at 0xFFFF, then SP=0x0000.
- Handshake:
  - CmdValid held high through a JUMP(0x1234) followed by LDAR(0x5678): PC=0x1234, then AR=0x5678.
  - Exactly one accept per IDLE cycle; changing Target during E1 does not alter the loaded value.
